trig_gen: RTL
=============

// Module: trig_gen
// PURPOSE
//   Transmit-trigger generator for the pulser front end. Consumes the run/mode/edge/cycle/pulse
//   settings produced by the command processor and drives the high-voltage pulser trigger
//   (o_trig) plus a one-clock start strobe to the ADC acquisition stage. It has two modes:
//   - Internal: trigger is a free-running periodic output.
//   - External: trigger is slaved to an asynchronous external trigger input.
//   Clock is 100 MHz; one count equals 10 ns.
// PARAMETERS
//   CYCLE_W    20  width of period count (10 ns units)
//   PULSE_W    12  width of pulse-high count (10 ns units)
//   CNT_W      32  width of trigger event counter
// PORTS
//   i_clk        in   1        system clock, 100 MHz
//   i_rst        in   1        synchronous reset, active-high
//   i_run        in   1        enable triggering (level)
//   i_outmode    in   1        0 = internal periodic, 1 = external trigger
//   i_outnegedge in   1        external mode: 0 = rising edge, 1 = falling edge of i_ext_trig
//   i_cycle      in   CYCLE_W  internal period C, in clocks
//   i_pulse      in   PULSE_W  pulse high width P, in clocks
//   i_ext_trig   in   1        external trigger, asynchronous to i_clk
//   o_trig       out  1        pulser trigger, registered
//   o_trig_start out  1        one-clock strobe in the first cycle o_trig is high
//   o_trig_cnt   out  CNT_W    count of triggers issued since run start
//   o_busy       out  1        high while state != IDLE
// BEHAVIOUR
//   Reset (sync, i_rst=1 at posedge): all outputs 0, state=IDLE, synchroniser flops 0, run_d=0.
//     Applies mid-pulse: o_trig drops at that edge with no completion.
//   ext synchroniser: i_ext_trig -> s1 -> s2 -> s3. Edge detect:
//     - rise = s2 & ~s3
//     - fall = ~s2 & s3
//     - sel = i_outnegedge ? fall : rise
//   Parameter latch at each trigger start (all arithmetic unsigned):
//     - Pe = (i_pulse==0) ? 1 : i_pulse
//     - Ce = (i_cycle<2) ? 2 : i_cycle
//     - if Pe >= Ce then Pe = Ce-1
//     Changes to i_cycle, i_pulse, i_outmode or i_outnegedge take effect at the next trigger start only.
//   States: IDLE, PULSE, GAP. Counters are pcnt and ccnt (CYCLE_W bits).
//   IDLE:
//     - Internal start: i_run & ~i_outmode.
//     - External start: i_run & i_outmode & sel.
//     - On start: o_trig<=1, o_trig_start<=1, latch Pe/Ce, pcnt<=1, ccnt<=1, o_trig_cnt<=o_trig_cnt+1, -> PULSE.
//   PULSE:
//     - Each clock: pcnt++, ccnt++.
//     - When pcnt==Pe: o_trig<=0, -> GAP.
//     - o_trig is high for exactly Pe clocks.
//   GAP, internal mode latched:
//     - When ccnt==Ce and i_run: restart exactly as in IDLE, so period = Ce clocks exactly.
//     - When ccnt==Ce and ~i_run: -> IDLE.
//   GAP, external mode latched: -> IDLE next clock. Edges arriving during PULSE/GAP are dropped (no queueing).
//   i_run deasserted mid-PULSE: the pulse completes its full Pe width. No new trigger starts afterwards.
//   o_trig_cnt:
//     - Cleared to 0 on an i_run 0->1 transition (run_d register). The clear has priority over increment.
//     - Wraps 2^CNT_W-1 -> 0.
//   Latency, internal: i_run sampled high in IDLE at edge N -> o_trig=1 after edge N.
//   Latency, external: i_ext_trig level first captured by s1 at edge N -> o_trig=1 after edge N+2.
//     This is the 3rd clock edge counting N, and is fixed.
//   o_trig_start: high exactly one clock per trigger and never without o_trig. It is 0 in all other cycles.
// TESTING
//   1. Internal mode, C=10, P=3, run=1 for 35 clk:
//      o_trig high 3 / low 7, starts at clk 1, 11, 21, 31. o_trig_cnt=4. After run=0, o_busy drops at period end.
//   2. External rising, P=5: single i_ext_trig 0->1:
//      o_trig rises exactly 3 edges after capture, high 5 clk, o_trig_cnt=1.
//      Falling edge with i_outnegedge=0 -> no trigger.
//   3. External negedge=1, second falling edge 2 clk into pulse:
//      dropped, only one trigger. A falling edge after return to IDLE triggers again.
//   4. Clamps:
//      - P=0, C=10 -> 1-clk pulses every 10.
//      - P=20, C=10 -> 9 high / 1 low.
//      - C=0 -> period 2, pulse 1.
//   5. Param change mid-period (C 10->4 at clk 5):
//      current period stays 10 clk, next period 4 clk.
//      Run toggle 0->1 clears o_trig_cnt to 0 then counts 1.
//   6. i_rst=1 mid-PULSE:
//      next edge has o_trig=0, o_busy=0, o_trig_cnt=0. With run still high after release, restart after 1 clk.

Source files
------------

// File: rtl/trig_gen.sv
// rtl/trig_gen.sv - transmit-trigger generator: internal periodic or external-edge pulser trigger
// Drives o_trig plus a one-clock ADC start strobe and counts triggers since run start.
module trig_gen #(
   parameter int CYCLE_W = 20,
   parameter int PULSE_W = 12,
   parameter int CNT_W   = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_run,
   input  logic               i_outmode,
   input  logic               i_outnegedge,
   input  logic [CYCLE_W-1:0] i_cycle,
   input  logic [PULSE_W-1:0] i_pulse,
   input  logic               i_ext_trig,
   output logic               o_trig,
   output logic               o_trig_start,
   output logic [CNT_W-1:0]   o_trig_cnt,
   output logic               o_busy
);
   typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

   state_t             state, state_n;
   logic               s1, s2, s3, run_d;
   logic               mode, mode_n;
   logic [CYCLE_W-1:0] pcnt, pcnt_n, ccnt, ccnt_n;
   logic [CYCLE_W-1:0] pe, pe_n, ce, ce_n;
   logic [CYCLE_W-1:0] pe_raw, ce_raw, pe_lim;
   logic               trig_n, strobe_n, start;
   logic [CNT_W-1:0]   cnt_n;
   logic               rise, fall, sel;

   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;
   assign sel  = i_outnegedge ? fall : rise;

   // Clamp so the pulse is never shorter than one clock and always leaves a low gap.
   assign pe_raw = (i_pulse == '0) ? CYCLE_W'(1) : CYCLE_W'(i_pulse);
   assign ce_raw = (i_cycle < CYCLE_W'(2)) ? CYCLE_W'(2) : i_cycle;
   assign pe_lim = (pe_raw >= ce_raw) ? ce_raw - CYCLE_W'(1) : pe_raw;

   assign o_busy = (state != IDLE);

   always_comb begin
      state_n  = state;
      pcnt_n   = pcnt;
      ccnt_n   = ccnt;
      pe_n     = pe;
      ce_n     = ce;
      mode_n   = mode;
      trig_n   = o_trig;
      strobe_n = 1'b0;
      start    = 1'b0;
      case (state)
         IDLE:  start = i_run & (i_outmode ? sel : 1'b1);
         PULSE: begin
            pcnt_n = pcnt + CYCLE_W'(1);
            ccnt_n = ccnt + CYCLE_W'(1);
            if (pcnt == pe) begin
               trig_n  = 1'b0;
               state_n = GAP;
            end
         end
         GAP: begin
            if (mode) begin
               state_n = IDLE;
            end else if (ccnt == ce) begin
               if (i_run & ~i_outmode) start = 1'b1;
               else                    state_n = IDLE;
            end else begin
               ccnt_n = ccnt + CYCLE_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
      if (start) begin
         trig_n   = 1'b1;
         strobe_n = 1'b1;
         pe_n     = pe_lim;
         ce_n     = ce_raw;
         mode_n   = i_outmode;
         pcnt_n   = CYCLE_W'(1);
         ccnt_n   = CYCLE_W'(1);
         state_n  = PULSE;
      end
      // A run restart discards the old total; a trigger on that same edge is its first count.
      if (i_run & ~run_d)  cnt_n = start ? CNT_W'(1) : '0;
      else if (start)      cnt_n = o_trig_cnt + CNT_W'(1);
      else                 cnt_n = o_trig_cnt;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= IDLE;
         s1           <= 1'b0;
         s2           <= 1'b0;
         s3           <= 1'b0;
         run_d        <= 1'b0;
         mode         <= 1'b0;
         pcnt         <= '0;
         ccnt         <= '0;
         pe           <= '0;
         ce           <= '0;
         o_trig       <= 1'b0;
         o_trig_start <= 1'b0;
         o_trig_cnt   <= '0;
      end else begin
         state        <= state_n;
         s1           <= i_ext_trig;
         s2           <= s1;
         s3           <= s2;
         run_d        <= i_run;
         mode         <= mode_n;
         pcnt         <= pcnt_n;
         ccnt         <= ccnt_n;
         pe           <= pe_n;
         ce           <= ce_n;
         o_trig       <= trig_n;
         o_trig_start <= strobe_n;
         o_trig_cnt   <= cnt_n;
      end
   end
endmodule
